time_setter: RTL and testbench
==============================

TIME_SETTER -- requirements
Module: time_setter

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000: number of consecutive stable samples before a button level is accepted.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
REQ-005 btn_inc  input  1  raw increment button, active-high, asynchronous to clk.
REQ-006 btn_dec  input  1  raw decrement button, active-high, asynchronous to clk.
REQ-007 time_in  input  24  running time from clock core; [7:0] sec, [15:8] min, [23:16] hour, binary.
REQ-008 time_out  output  24  edited time, same field layout as time_in.
REQ-009 load  output  1  one-cycle pulse; clock core takes time_out as its new time.
REQ-010 setting  output  1  high in any SET state; clock core holds its count while high.
REQ-011 second_flash, minute_flash, hour_flash  output  1 each  high while the matching field is being edited; drive the display flash inputs.

Function
REQ-012 Each button passes a 2-flop synchronizer, then a debouncer; the accepted level changes only after DEBOUNCE_CYCLES identical synchronized samples.
REQ-013 A press event is a one-cycle pulse on the 0->1 edge of the accepted level; holding a button produces exactly one event.
REQ-014 FSM states: IDLE, SET_HOUR, SET_MIN, SET_SEC.
REQ-015 IDLE + mode event -> SET_HOUR; on that edge the edit register captures time_in.
REQ-016 SET_HOUR + mode -> SET_MIN; SET_MIN + mode -> SET_SEC; SET_SEC + mode -> IDLE.
REQ-017 SET_SEC -> IDLE transition asserts load for exactly one cycle, and time_out holds the edited value in that cycle.
REQ-018 In IDLE, time_out equals time_in registered (1-cycle latency); the edit register is not visible.
REQ-019 In SET states, time_out equals the edit register.
REQ-020 Inc event adds 1 to the active field; hour wraps 23->0, min/sec wrap 59->0.
REQ-021 Dec event subtracts 1 from the active field; hour wraps 0->23, min/sec wrap 0->59.
REQ-022 Inactive fields are never modified by inc/dec.
REQ-023 Inc and dec events in the same cycle: both ignored, field unchanged.
REQ-024 Mode event in the same cycle as inc/dec: mode wins; the state advances and inc/dec is discarded.
REQ-025 Inc/dec events in IDLE are ignored.
REQ-026 Exactly one flash output is high per SET state: SET_HOUR->hour_flash, SET_MIN->minute_flash, SET_SEC->second_flash; all low in IDLE.
REQ-027 setting = (state != IDLE); all outputs are registered.
REQ-028 A field value out of range at capture (e.g. 60) is clamped to 0 on the first inc and to max on the first dec.

Reset
REQ-029 While rst_n=0: state=IDLE, time_out=0, edit register=0, load=0, setting=0, all flash=0, synchronizers/debouncers cleared to released (0).
REQ-030 Reset during a SET state abandons the edit; no load pulse is produced, either during reset or after release.
REQ-031 A button held through reset release produces no event until it is released and pressed again.

Structure
REQ-032 Shared package clock_pkg holds HOUR_MAX=23, MIN_MAX=59, SEC_MAX=59, the field bit offsets, and the FSM state encoding.
REQ-033 One sub-module, btn_debounce (synchronizer + debounce counter + rising-edge pulse), instantiated three times.
REQ-034 time_setter contains only the FSM, the edit register, the field arithmetic, and output registers.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-035 time_in=12:34:56, press mode -> setting=1, hour_flash=1, time_out=0x0C_22_38 (12:34:56).
REQ-036 In SET_HOUR from hour=23, press inc -> hour=0; press dec -> hour=23; min/sec unchanged.
REQ-037 Mode x4 with one inc in SET_MIN starting at 10:59:00 -> min=0, single load pulse, time_out=10:00:00, setting=0.
REQ-038 Button bouncing 1-0-1 with runs of 2 cycles, then stable -> exactly one event after 4 stable cycles.
REQ-039 Inc+dec asserted together in SET_SEC -> no change; mode+inc together in SET_MIN -> SET_SEC, min unchanged.
REQ-040 Assert rst_n=0 in SET_MIN -> all outputs 0 asynchronously; after release, state=IDLE and load is never asserted.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared constants for the clock time-setting path: field limits, field
// bit offsets within the 24-bit time word, and the setter FSM encoding.
package clock_pkg;

    localparam int FIELD_W  = 8;
    localparam int TIME_W   = 24;

    localparam int SEC_LSB  = 0;
    localparam int MIN_LSB  = 8;
    localparam int HOUR_LSB = 16;

    localparam logic [FIELD_W-1:0] HOUR_MAX = 8'd23;
    localparam logic [FIELD_W-1:0] MIN_MAX  = 8'd59;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'd59;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_SEC  = 2'd3
    } state_e;

    // One inc/dec step with wrap; values already beyond lim snap to 0 (up)
    // or to lim (down) so a bad captured value recovers in a single press.
    function automatic logic [FIELD_W-1:0] field_step(
        input logic [FIELD_W-1:0] val,
        input logic [FIELD_W-1:0] lim,
        input logic               up
    );
        logic [FIELD_W-1:0] res;
        if (up) begin
            res = (val >= lim) ? '0 : val + 1'b1;
        end else begin
            res = ((val == '0) || (val > lim)) ? lim : val - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioning: 2-flop synchronizer, stable-sample debounce counter
// and a one-cycle press pulse on the accepted 0->1 edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          level_d1_q;
    logic          armed_q;

    // Until a debounced release has been seen the button is not armed, so a
    // button held through reset release cannot produce a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            level_d1_q <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], btn};
            level_d1_q <= level_q;
            if (!armed_q) begin
                level_q <= 1'b0;
                if (sync_q[1]) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    armed_q <= 1'b1;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (sync_q[1] != level_q) begin
                if (cnt_q == LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign press = level_q & ~level_d1_q;

endmodule

// File: rtl/time_setter.sv
// Time-setting front end: mode/inc/dec buttons walk hour, minute and second
// edit states and hand the edited time back to the clock core with a load pulse.
module time_setter
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              btn_dec,
    input  logic [TIME_W-1:0] time_in,
    output logic [TIME_W-1:0] time_out,
    output logic              load,
    output logic              setting,
    output logic              second_flash,
    output logic              minute_flash,
    output logic              hour_flash,
    output state_e            state_dbg
);

    logic mode_ev, inc_ev, dec_ev;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
        .clk(clk), .rst_n(rst_n), .btn(btn_mode), .press(mode_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_inc (
        .clk(clk), .rst_n(rst_n), .btn(btn_inc), .press(inc_ev)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dec (
        .clk(clk), .rst_n(rst_n), .btn(btn_dec), .press(dec_ev)
    );

    state_e            state_q, next_state;
    logic [TIME_W-1:0] edit_q, edit_d;
    logic [TIME_W-1:0] time_out_d;
    logic              load_d;
    logic              step_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            edit_q       <= '0;
            time_out     <= '0;
            load         <= 1'b0;
            setting      <= 1'b0;
            hour_flash   <= 1'b0;
            minute_flash <= 1'b0;
            second_flash <= 1'b0;
        end else begin
            state_q      <= next_state;
            edit_q       <= edit_d;
            time_out     <= time_out_d;
            load         <= load_d;
            setting      <= (next_state != IDLE);
            hour_flash   <= (next_state == SET_HOUR);
            minute_flash <= (next_state == SET_MIN);
            second_flash <= (next_state == SET_SEC);
        end
    end

    // Simultaneous inc and dec cancel; a mode event always takes priority.
    assign step_en = inc_ev ^ dec_ev;

    always_comb begin
        next_state = state_q;
        edit_d     = edit_q;
        load_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (mode_ev) begin
                    next_state = SET_HOUR;
                    edit_d     = time_in;
                end
            end
            SET_HOUR: begin
                if (mode_ev) begin
                    next_state = SET_MIN;
                end else if (step_en) begin
                    edit_d[HOUR_LSB +: FIELD_W] =
                        field_step(edit_q[HOUR_LSB +: FIELD_W], HOUR_MAX, inc_ev);
                end
            end
            SET_MIN: begin
                if (mode_ev) begin
                    next_state = SET_SEC;
                end else if (step_en) begin
                    edit_d[MIN_LSB +: FIELD_W] =
                        field_step(edit_q[MIN_LSB +: FIELD_W], MIN_MAX, inc_ev);
                end
            end
            SET_SEC: begin
                if (mode_ev) begin
                    next_state = IDLE;
                    load_d     = 1'b1;
                end else if (step_en) begin
                    edit_d[SEC_LSB +: FIELD_W] =
                        field_step(edit_q[SEC_LSB +: FIELD_W], SEC_MAX, inc_ev);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The load cycle still shows the edited value; afterwards time_out tracks time_in.
    assign time_out_d = ((next_state == IDLE) && !load_d) ? time_in : edit_d;

    assign state_dbg = state_q;

endmodule

// File: tb/tb_time_setter.sv
// Directed bench for time_setter with a short debounce window; expected
// times are hand-computed hh:mm:ss words.
module tb_time_setter;
    import clock_pkg::*;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [23:0] time_in = '0;
    logic [23:0] time_out;
    logic        load;
    logic        setting;
    logic        second_flash;
    logic        minute_flash;
    logic        hour_flash;
    state_e      state_dbg;

    int          checks = 0;
    int          errors = 0;
    int          load_cnt = 0;
    logic [23:0] load_val = '0;

    time_setter #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .time_in(time_in), .time_out(time_out), .load(load),
        .setting(setting), .second_flash(second_flash),
        .minute_flash(minute_flash), .hour_flash(hour_flash),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // load pulse monitor, sampled away from the active edge
    always @(negedge clk) begin
        if (load) begin
            load_cnt = load_cnt + 1;
            load_val = time_out;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic i, input logic d);
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        cycles(14);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        cycles(14);
    endtask

    task automatic check_flags(input string tag, input logic s, input logic h,
                               input logic m, input logic sc, input state_e st);
        check({tag, ".setting"}, {31'd0, setting}, {31'd0, s});
        check({tag, ".hour_flash"}, {31'd0, hour_flash}, {31'd0, h});
        check({tag, ".minute_flash"}, {31'd0, minute_flash}, {31'd0, m});
        check({tag, ".second_flash"}, {31'd0, second_flash}, {31'd0, sc});
        check({tag, ".state"}, {30'd0, state_dbg}, {30'd0, st});
    endtask

    initial begin
        // reset state
        cycles(3);
        check("rst.time_out", {8'd0, time_out}, 32'h0);
        check("rst.load", {31'd0, load}, 32'h0);
        check_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        rst_n = 1'b1;
        cycles(20);

        // IDLE follows time_in; inc ignored
        time_in = 24'h0C2238;
        cycles(2);
        check("idle.follow", {8'd0, time_out}, 32'h0C2238);
        press(1'b0, 1'b1, 1'b0);
        check("idle.inc_ignored", {8'd0, time_out}, 32'h0C2238);
        check_flags("idle", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // enter SET_HOUR at 12:34:56
        press(1'b1, 1'b0, 1'b0);
        check_flags("set_hour", 1'b1, 1'b1, 1'b0, 1'b0, SET_HOUR);
        check("set_hour.capture", {8'd0, time_out}, 32'h0C2238);
        time_in = 24'h000000;
        cycles(2);
        check("set_hour.no_follow", {8'd0, time_out}, 32'h0C2238);
        press(1'b0, 1'b0, 1'b1);
        check("set_hour.dec", {8'd0, time_out}, 32'h0B2238);
        press(1'b0, 1'b1, 1'b0);
        check("set_hour.inc", {8'd0, time_out}, 32'h0C2238);

        // SET_MIN: plain inc, then bounced inc giving exactly one event
        press(1'b1, 1'b0, 1'b0);
        check_flags("set_min", 1'b1, 1'b0, 1'b1, 1'b0, SET_MIN);
        press(1'b0, 1'b1, 1'b0);
        check("set_min.inc", {8'd0, time_out}, 32'h0C2338);
        for (int k = 0; k < 4; k++) begin
            btn_inc = (k % 2 == 0);
            cycles(2);
        end
        btn_inc = 1'b1;
        cycles(3);
        check("bounce.early", {8'd0, time_out}, 32'h0C2338);
        cycles(12);
        check("bounce.one_event", {8'd0, time_out}, 32'h0C2438);
        cycles(20);
        check("bounce.held", {8'd0, time_out}, 32'h0C2438);
        btn_inc = 1'b0;
        cycles(14);

        // mode + inc together: mode wins, minute untouched
        press(1'b1, 1'b1, 1'b0);
        check_flags("mode_inc", 1'b1, 1'b0, 1'b0, 1'b1, SET_SEC);
        check("mode_inc.value", {8'd0, time_out}, 32'h0C2438);

        // SET_SEC: inc+dec cancel, then inc and two decs
        press(1'b0, 1'b1, 1'b1);
        check("inc_dec.cancel", {8'd0, time_out}, 32'h0C2438);
        press(1'b0, 1'b1, 1'b0);
        check("set_sec.inc", {8'd0, time_out}, 32'h0C2439);
        press(1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        check("set_sec.dec2", {8'd0, time_out}, 32'h0C2437);

        // back to IDLE with a single load
        time_in = 24'h010203;
        press(1'b1, 1'b0, 1'b0);
        check("load1.count", load_cnt, 32'd1);
        check("load1.value", {8'd0, load_val}, 32'h0C2437);
        check("load1.after", {8'd0, time_out}, 32'h010203);
        check_flags("load1", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);

        // wraps from 23:59:59
        time_in = 24'h173B3B;
        cycles(2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("hour.wrap_up", {8'd0, time_out}, 32'h003B3B);
        press(1'b0, 1'b0, 1'b1);
        check("hour.wrap_down", {8'd0, time_out}, 32'h173B3B);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("min.wrap_up", {8'd0, time_out}, 32'h17003B);
        press(1'b0, 1'b0, 1'b1);
        check("min.wrap_down", {8'd0, time_out}, 32'h173B3B);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("sec.wrap_up", {8'd0, time_out}, 32'h173B00);
        press(1'b0, 1'b0, 1'b1);
        check("sec.wrap_down", {8'd0, time_out}, 32'h173B3B);
        press(1'b1, 1'b0, 1'b0);
        check("load2.count", load_cnt, 32'd2);
        check("load2.value", {8'd0, load_val}, 32'h173B3B);

        // 10:59:00, one inc in SET_MIN, four modes
        time_in = 24'h0A3B00;
        cycles(2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check("load3.count", load_cnt, 32'd3);
        check("load3.value", {8'd0, load_val}, 32'h0A0000);
        check("load3.setting", {31'd0, setting}, 32'h0);

        // out-of-range capture 60:60:60 clamps on first step
        time_in = 24'h3C3C3C;
        cycles(2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("clamp.hour_inc", {8'd0, time_out}, 32'h003C3C);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        check("clamp.min_dec", {8'd0, time_out}, 32'h003B3C);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        check("clamp.sec_inc", {8'd0, time_out}, 32'h003B00);
        press(1'b1, 1'b0, 1'b0);
        check("load4.count", load_cnt, 32'd4);

        // reset in SET_MIN abandons the edit
        time_in = 24'h050607;
        cycles(2);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        check_flags("pre_rst", 1'b1, 1'b0, 1'b1, 1'b0, SET_MIN);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst.time_out", {8'd0, time_out}, 32'h0);
        check("async_rst.load", {31'd0, load}, 32'h0);
        check_flags("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        cycles(3);
        rst_n = 1'b1;
        cycles(40);
        check_flags("post_rst", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        check("post_rst.load_cnt", load_cnt, 32'd4);
        check("post_rst.follow", {8'd0, time_out}, 32'h050607);

        // mode held through reset release gives no event until re-pressed
        rst_n = 1'b0;
        btn_mode = 1'b1;
        cycles(3);
        rst_n = 1'b1;
        cycles(40);
        check_flags("held_rst", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        btn_mode = 1'b0;
        cycles(20);
        check_flags("held_release", 1'b0, 1'b0, 1'b0, 1'b0, IDLE);
        press(1'b1, 1'b0, 1'b0);
        check_flags("held_repress", 1'b1, 1'b1, 1'b0, 1'b0, SET_HOUR);
        check("held_repress.value", {8'd0, time_out}, 32'h050607);
        check("final.load_cnt", load_cnt, 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
